// File: rtl/fifo_stream.sv
// Synchronous valid/ready FIFO with fill counter, programmable almost-full/empty flags,
// a peak-usage monitor and optional zero-latency fall-through when empty.
module fifo_stream #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter bit          FALL_THROUGH = 1'b0,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             testmode_i,
  input  dtype             data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output dtype             data_o,
  output logic             valid_o,
  input  logic             ready_i,
  input  logic [CNT_W-1:0] afull_thresh_i,
  input  logic [CNT_W-1:0] aempty_thresh_i,
  output logic [CNT_W-1:0] usage_o,
  output logic [CNT_W-1:0] peak_o,
  input  logic             clr_peak_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             afull_o,
  output logic             aempty_o
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  dtype             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_usage, r_peak;
  logic [CNT_W-1:0] w_usage_next, w_peak_next;
  logic             w_full, w_empty, w_fall, w_push, w_pop, w_bypass;
  logic             w_store, w_fetch;
  logic             w_unused;

  assign w_unused = testmode_i;

  assign w_full  = (r_usage == FULL_CNT);
  assign w_empty = (r_usage == '0);

  assign ready_o = !w_full && !flush_i;
  assign w_fall  = FALL_THROUGH && w_empty && valid_i && !flush_i;
  assign valid_o = (!w_empty && !flush_i) || w_fall;

  assign w_push   = valid_i && ready_o;
  assign w_pop    = valid_o && ready_i;
  // An item consumed in the same cycle it arrives at an empty FIFO never touches storage.
  assign w_bypass = w_fall && ready_i;
  assign w_store  = w_push && !w_bypass;
  assign w_fetch  = w_pop && !w_bypass;

  always_comb begin
    data_o = '0;
    if (valid_o) begin
      data_o = w_empty ? data_i : r_mem[r_rd_ptr];
    end
  end

  always_comb begin
    w_usage_next = r_usage;
    if (flush_i) begin
      w_usage_next = '0;
    end else if (w_push && !w_pop) begin
      w_usage_next = r_usage + 1'b1;
    end else if (w_pop && !w_push) begin
      w_usage_next = r_usage - 1'b1;
    end
  end

  always_comb begin
    w_peak_next = (r_peak > w_usage_next) ? r_peak : w_usage_next;
    if (clr_peak_i) begin
      w_peak_next = w_usage_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usage  <= '0;
      r_peak   <= '0;
    end else begin
      r_usage <= w_usage_next;
      r_peak  <= w_peak_next;
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_store) begin
          r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
        end
        if (w_fetch) begin
          r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  assign usage_o  = r_usage;
  assign peak_o   = r_peak;
  assign full_o   = w_full;
  assign empty_o  = w_empty;
  assign afull_o  = (r_usage >= afull_thresh_i);
  assign aempty_o = (r_usage <= aempty_thresh_i);

endmodule

// File: tb/tb_fifo_stream.sv
// Scoreboard bench for fifo_stream: three instances (depth 8, depth 5, depth 6 fall-through)
// checked against a queue-based reference model.
module tb_fifo_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tm = 1'b0;
  always #5 clk = ~clk;

  logic       vin [3], rin [3], fl [3], cl [3];
  logic [7:0] din [3];
  logic [3:0] afth [3], aeth [3];
  logic       rdy [3], vout [3], full [3], empty [3], af [3], ae [3];
  logic [7:0] dout [3];
  logic [3:0] usage [3], peak [3];

  logic [7:0]  exp_q [3][$];
  int unsigned m_peak [3];
  bit          m_clr_prev [3];
  int checks = 0;
  int failures = 0;

  function automatic int unsigned dep(int g);
    return (g == 0) ? 8 : ((g == 1) ? 5 : 6);
  endfunction

  function automatic bit ft(int g);
    return (g == 2);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned D  = (g == 0) ? 8 : ((g == 1) ? 5 : 6);
    localparam bit          FT = (g == 2);
    localparam int unsigned CW = $clog2(D + 1);
    logic [CW-1:0] w_usage, w_peak;
    fifo_stream #(
      .DATA_WIDTH  (8),
      .DEPTH       (D),
      .FALL_THROUGH(FT)
    ) u_dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .flush_i        (fl[g]),
      .testmode_i     (tm),
      .data_i         (din[g]),
      .valid_i        (vin[g]),
      .ready_o        (rdy[g]),
      .data_o         (dout[g]),
      .valid_o        (vout[g]),
      .ready_i        (rin[g]),
      .afull_thresh_i (afth[g][CW-1:0]),
      .aempty_thresh_i(aeth[g][CW-1:0]),
      .usage_o        (w_usage),
      .peak_o         (w_peak),
      .clr_peak_i     (cl[g]),
      .full_o         (full[g]),
      .empty_o        (empty[g]),
      .afull_o        (af[g]),
      .aempty_o       (ae[g])
    );
    assign usage[g] = 4'(w_usage);
    assign peak[g]  = 4'(w_peak);
  end

  task automatic chk(int g, string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL g%0d %s: got %0d, required %0d (t=%0t)", g, name, act, req, $time);
    end
  endtask

  // Monitor: every accepted output beat must match the oldest expected item.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      for (int g = 0; g < 3; g++) begin
        if (vout[g] && rin[g]) begin
          checks++;
          if (exp_q[g].size() == 0) begin
            failures++;
            $display("FAIL g%0d pop_unexpected: got data %0h, required no valid beat", g, dout[g]);
          end else begin
            e = exp_q[g].pop_front();
            if (dout[g] !== e) begin
              failures++;
              $display("FAIL g%0d data_order: got %0h, required %0h (t=%0t)", g, dout[g], e, $time);
            end
          end
        end
      end
    end
  end

  // One clock cycle of stimulus on instance g; entered and left at posedge+1.
  task automatic step(int g, bit v, bit r, logic [7:0] d, bit f, bit c);
    int unsigned sz;
    bit e_rdy, e_val;
    sz = exp_q[g].size();
    if (m_clr_prev[g]) m_peak[g] = sz;
    else if (sz > m_peak[g]) m_peak[g] = sz;
    m_clr_prev[g] = c;
    vin[g] = v; rin[g] = r; din[g] = d; fl[g] = f; cl[g] = c;
    e_rdy = (sz < dep(g)) && !f;
    e_val = !f && ((sz > 0) || (ft(g) && v));
    if (v && e_rdy) exp_q[g].push_back(d);
    if (f) exp_q[g].delete();
    @(negedge clk);
    chk(g, "ready_o", int'(rdy[g]), int'(e_rdy));
    chk(g, "valid_o", int'(vout[g]), int'(e_val));
    chk(g, "usage_o", int'(usage[g]), int'(sz));
    chk(g, "full_o", int'(full[g]), int'(sz == dep(g)));
    chk(g, "empty_o", int'(empty[g]), int'(sz == 0));
    chk(g, "afull_o", int'(af[g]), int'(sz >= afth[g]));
    chk(g, "aempty_o", int'(ae[g]), int'(sz <= aeth[g]));
    chk(g, "peak_o", int'(peak[g]), int'(m_peak[g]));
    if (!e_val) chk(g, "data_o_idle", int'(dout[g]), 0);
    @(posedge clk);
    #1;
    vin[g] = 1'b0; rin[g] = 1'b0; fl[g] = 1'b0; cl[g] = 1'b0;
  endtask

  task automatic check_reset_vals();
    for (int g = 0; g < 3; g++) begin
      chk(g, "rst_usage", int'(usage[g]), 0);
      chk(g, "rst_peak", int'(peak[g]), 0);
      chk(g, "rst_empty", int'(empty[g]), 1);
      chk(g, "rst_full", int'(full[g]), 0);
      chk(g, "rst_ready", int'(rdy[g]), 1);
      chk(g, "rst_valid", int'(vout[g]), 0);
      chk(g, "rst_data", int'(dout[g]), 0);
      chk(g, "rst_aempty", int'(ae[g]), 1);
      chk(g, "rst_afull", int'(af[g]), int'(afth[g] == 0));
    end
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    for (int g = 0; g < 3; g++) begin
      exp_q[g].delete();
      m_peak[g] = 0;
      m_clr_prev[g] = 1'b0;
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      vin[g] = 1'b0; rin[g] = 1'b0; fl[g] = 1'b0; cl[g] = 1'b0; din[g] = 8'h00;
      m_peak[g] = 0; m_clr_prev[g] = 1'b0;
    end
    afth[0] = 4'd6; aeth[0] = 4'd2;
    afth[1] = 4'd0; aeth[1] = 4'd1;
    afth[2] = 4'd5; aeth[2] = 4'd1;
    #3;
    check_reset_vals();
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill past full with consumer stalled, then drain in order.
    for (int i = 0; i < 9; i++) step(0, 1'b1, 1'b0, 8'(8'hA0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // Live threshold change takes effect in the same cycle.
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 8'(8'hB0 + i), 1'b0, 1'b0);
    afth[0] = 4'd3;
    step(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    afth[0] = 4'd6;

    // Peak: clear at 4, fill to 6, drain to 1, clear at 1.
    step(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(0, 1'b1, 1'b0, 8'(8'hB4 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Flush at usage 4 with a concurrent write attempt.
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 8'hCC, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset between edges while filling.
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 8'(8'hD0 + i), 1'b0, 1'b0);
    mid_reset();
    step(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Fall-through bypass on an empty FIFO.
    step(2, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(2, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0);
    step(2, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // Randomised traffic with alternating fill/drain bias.
    for (int g = 0; g < 3; g++) begin
      for (int n = 0; n < 400; n++) begin
        int unsigned pv, pr;
        pv = ((n % 60) < 30) ? 80 : 30;
        pr = 110 - pv;
        if ($urandom_range(0, 19) == 0) afth[g] = 4'($urandom_range(0, dep(g)));
        if ($urandom_range(0, 19) == 0) aeth[g] = 4'($urandom_range(0, dep(g)));
        step(g, $urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr, 8'($urandom),
             $urandom_range(0, 79) == 0, $urandom_range(0, 39) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_stream.md
# fifo_stream

Parametrised synchronous FIFO with valid/ready stream handshakes on both sides, a correctly sized fill-level counter, and runtime-programmable almost-full/almost-empty thresholds. It also has a peak-usage (high-watermark) monitor and supports depths that are not a power of two. It sits between stream producers and consumers as the general-purpose buffering primitive for the datapath.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width when dtype is left at its default.
- DEPTH, 8, number of entries; must be at least 1; any integer is allowed.
- FALL_THROUGH, 1'b0, when 1 an empty FIFO forwards data_i to data_o in the same cycle.
- dtype, logic [DATA_WIDTH-1:0], payload type.
- CNT_W, $clog2(DEPTH+1), derived width of the counter and thresholds; must not be overridden.

Ports:
- clk_i  in  1  clock; one clock domain, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; discards all contents.
- testmode_i  in  1  reserved for DFT; no functional effect.
- data_i  in  dtype  write payload.
- valid_i  in  1  write request.
- ready_o  out  1  FIFO can accept data.
- data_o  out  dtype  read payload.
- valid_o  out  1  read data available.
- ready_i  in  1  consumer accepts data.
- afull_thresh_i  in  CNT_W  almost-full threshold.
- aempty_thresh_i  in  CNT_W  almost-empty threshold.
- usage_o  out  CNT_W  number of stored entries, 0..DEPTH.
- peak_o  out  CNT_W  maximum usage_o since reset or the last clear.
- clr_peak_i  in  1  clear the peak monitor.
- full_o, empty_o, afull_o, aempty_o  out  1 each  status flags.

## Operation
- A push occurs when valid_i && ready_o; a pop occurs when valid_o && ready_i.
- ready_o = !full_o && !flush_i.
  - ready_o never depends on ready_i, so a full FIFO refuses a push even when a pop happens in the same cycle.
- valid_o = !empty_o && !flush_i in normal mode.
  - With FALL_THROUGH=1 it is additionally asserted when empty_o && valid_i && !flush_i.
- data_o = storage[rd_ptr] when stored data is valid; data_i in the fall-through case; '0 whenever valid_o=0.
- Storage is a DEPTH-entry register array with wr_ptr and rd_ptr.
  - Each pointer advances on its event and wraps from DEPTH-1 to 0; DEPTH does not need to be a power of two.
  - The storage array is not reset.
- Fall-through bypass: when empty, a push and pop in the same cycle pass the item straight through; nothing is written and usage is unchanged.
- usage next-state rules:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- full_o = (usage==DEPTH); empty_o = (usage==0).
- afull_o = (usage_o >= afull_thresh_i); aempty_o = (usage_o <= aempty_thresh_i).
  - Both are combinational from registered usage and the live threshold inputs.
  - Comparisons are unsigned, CNT_W wide.
- Peak monitor: peak_o <= max(peak_o, usage_next) each cycle. With clr_peak_i, peak_o <= usage_next.
- Flush: rd_ptr, wr_ptr and usage clear to 0 on the next edge, and all handshakes in the flush cycle are suppressed. peak_o is not affected; only the update rule above applies.

## Timing
- Reset values: usage_o=0, peak_o=0, empty_o=1, full_o=0, ready_o=1, valid_o=0, data_o='0, aempty_o=1.
  - afull_o is 1 after reset only if afull_thresh_i==0.
- Normal mode latency: an item pushed at edge N gives valid_o=1 in cycle N+1.
- Fall-through latency: 0 cycles when the FIFO is empty.
- Status flags and usage_o reflect the state after the previous edge.
- Reset asserted mid-operation clears everything asynchronously; contents are lost.

## Test plan
- DEPTH=8, normal mode:
  - Push 0xA0..0xA7 back-to-back with ready_i=0 -> usage_o reaches 8, full_o=1, ready_o=0; a 9th valid_i is not accepted.
  - Pop all entries -> data_o reads 0xA0..0xA7 in order, then empty_o=1, valid_o=0, data_o=0.
- DEPTH=5, run 23 push/pop pairs with random valid/ready -> order preserved across several pointer wraps; usage_o never exceeds 5.
- FALL_THROUGH=1, empty FIFO, valid_i=1, ready_i=1, data_i=0x55 -> same cycle valid_o=1 and data_o=0x55; usage_o stays 0.
- Thresholds afull_thresh_i=6, aempty_thresh_i=2 with DEPTH=8, fill one item at a time:
  - aempty_o=1 for usage 0..2, then 0.
  - afull_o=1 from usage 6.
  - Changing afull_thresh_i to 3 at usage 4 sets afull_o=1 in the same cycle.
- Fill to 6, drain to 1 -> peak_o=6. Assert clr_peak_i at usage 1 -> peak_o=1 on the next cycle.
- Fill to 4, then assert flush_i together with valid_i=1 -> ready_o=0 in that cycle; next cycle usage_o=0, empty_o=1, valid_o=0.
- Assert rst_ni=0 mid-fill between clock edges -> all outputs immediately take their reset values.
